// File: rtl/sev_seg_pkg.sv
// Shared definitions for the seven-segment controller: register map,
// CTRL field positions and the hex-to-segment decode table.
package sev_seg_pkg;

    localparam logic [2:0] ADDR_HEXVAL    = 3'd0;
    localparam logic [2:0] ADDR_CTRL      = 3'd1;
    localparam logic [2:0] ADDR_RAW_LO    = 3'd2;
    localparam logic [2:0] ADDR_RAW_HI    = 3'd3;
    localparam logic [2:0] ADDR_BLINK_DIV = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_MODE_BIT  = 1;
    localparam int CTRL_BLANK_LSB = 8;
    localparam int CTRL_BLINK_LSB = 16;

    // bit0 = a .. bit6 = g, 1 = lit
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0:    p = 7'h3F;
            4'h1:    p = 7'h06;
            4'h2:    p = 7'h5B;
            4'h3:    p = 7'h4F;
            4'h4:    p = 7'h66;
            4'h5:    p = 7'h6D;
            4'h6:    p = 7'h7D;
            4'h7:    p = 7'h07;
            4'h8:    p = 7'h7F;
            4'h9:    p = 7'h6F;
            4'hA:    p = 7'h77;
            4'hB:    p = 7'h7C;
            4'hC:    p = 7'h39;
            4'hD:    p = 7'h5E;
            4'hE:    p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sev_seg_blink_timer.sv
// Blink phase generator: down-counter reloaded from the divider,
// toggling the phase each time it expires.
module sev_seg_blink_timer #(
    parameter logic [31:0] DIV_RST = 32'd12_500_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic [31:0] div_i,
    output logic        phase_o
);

    logic [31:0] cnt_q, cnt_d;
    logic        phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load_i) begin
            cnt_d   = load_val_i;
            phase_d = 1'b0;
        end else if (div_i != '0) begin
            if (cnt_q == '0) begin
                cnt_d   = div_i;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q - 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= DIV_RST;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/sev_seg_ctrl.sv
// Avalon-MM seven-segment controller for NUM_DIGITS digits.
// Define SEV_SEG_BLINK_EN to build the blink timer, blink mask, BLINK_DIV and STATUS.
module sev_seg_ctrl
    import sev_seg_pkg::*;
#(
    parameter int          NUM_DIGITS    = 4,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned BLINK_DIV_RST = 32'd12_500_000
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic [2:0]              s1_address,
    input  logic                    s1_write,
    input  logic [31:0]             s1_writedata,
    input  logic                    s1_read,
    output logic [31:0]             s1_readdata,
    output logic [7*NUM_DIGITS-1:0] seg_out
);

    localparam int ND = NUM_DIGITS;
    localparam logic [7*ND-1:0] SEG_OFF = {(7*ND){ACTIVE_LOW}};

    logic [4*ND-1:0]    hex_q;
    logic               en_q;
    logic               mode_q;
    logic [ND-1:0]      blank_q;
    logic [ND-1:0][6:0] raw_q;
    logic [ND-1:0]      blink_m;
    logic [31:0]        div_rd;
    logic               phase;
    logic [31:0]        rd_d, rd_q;
    logic [ND-1:0][6:0] pat;
    logic [7*ND-1:0]    seg_d, seg_q;
    logic               wr_hex, wr_ctrl, wr_lo, wr_hi;
    logic               unused_wdata;

    assign wr_hex  = s1_write && (s1_address == ADDR_HEXVAL);
    assign wr_ctrl = s1_write && (s1_address == ADDR_CTRL);
    assign wr_lo   = s1_write && (s1_address == ADDR_RAW_LO);
    assign wr_hi   = s1_write && (s1_address == ADDR_RAW_HI);

    // Bits above the configured digit count are simply not stored
    assign unused_wdata = ^s1_writedata;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            hex_q   <= '0;
            en_q    <= 1'b0;
            mode_q  <= 1'b0;
            blank_q <= '0;
            raw_q   <= '0;
        end else begin
            if (wr_hex) hex_q <= s1_writedata[4*ND-1:0];
            if (wr_ctrl) begin
                en_q    <= s1_writedata[CTRL_EN_BIT];
                mode_q  <= s1_writedata[CTRL_MODE_BIT];
                blank_q <= s1_writedata[CTRL_BLANK_LSB +: ND];
            end
            for (int i = 0; i < ND; i++) begin
                if ((i < 4) ? wr_lo : wr_hi)
                    raw_q[i] <= s1_writedata[7*(i%4) +: 7];
            end
        end
    end

`ifdef SEV_SEG_BLINK_EN
    logic          wr_div;
    logic [31:0]   div_q;
    logic [ND-1:0] blink_q;

    assign wr_div = s1_write && (s1_address == ADDR_BLINK_DIV);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            div_q   <= BLINK_DIV_RST;
            blink_q <= '0;
        end else begin
            if (wr_div)  div_q   <= s1_writedata;
            if (wr_ctrl) blink_q <= s1_writedata[CTRL_BLINK_LSB +: ND];
        end
    end

    sev_seg_blink_timer #(
        .DIV_RST    (BLINK_DIV_RST)
    ) u_timer (
        .clk_i      (clk_clk),
        .rst_ni     (reset_reset_n),
        .load_i     (wr_div),
        .load_val_i (s1_writedata),
        .div_i      (div_q),
        .phase_o    (phase)
    );

    assign blink_m = blink_q;
    assign div_rd  = div_q;
`else
    assign blink_m = '0;
    assign div_rd  = '0;
    assign phase   = 1'b0;
`endif

    // Read mux sees pre-write state, so a same-cycle write is not visible
    always_comb begin
        rd_d = '0;
        case (s1_address)
            ADDR_HEXVAL: rd_d[4*ND-1:0] = hex_q;
            ADDR_CTRL: begin
                rd_d[CTRL_EN_BIT]           = en_q;
                rd_d[CTRL_MODE_BIT]         = mode_q;
                rd_d[CTRL_BLANK_LSB +: ND]  = blank_q;
                rd_d[CTRL_BLINK_LSB +: ND]  = blink_m;
            end
            ADDR_RAW_LO: begin
                for (int i = 0; i < ND; i++)
                    if (i < 4) rd_d[7*(i%4) +: 7] = raw_q[i];
            end
            ADDR_RAW_HI: begin
                for (int i = 0; i < ND; i++)
                    if (i >= 4) rd_d[7*(i%4) +: 7] = raw_q[i];
            end
            ADDR_BLINK_DIV: rd_d = div_rd;
            ADDR_STATUS:    rd_d[0] = phase;
            default:        rd_d = '0;
        endcase
    end

    always_comb begin
        pat   = '0;
        seg_d = SEG_OFF;
        for (int i = 0; i < ND; i++) begin
            if (!en_q || blank_q[i])
                pat[i] = 7'h00;
            else if (blink_m[i] && phase)
                pat[i] = 7'h00;
            else if (!mode_q)
                pat[i] = hex7(hex_q[4*i +: 4]);
            else
                pat[i] = raw_q[i];
            seg_d[7*i +: 7] = ACTIVE_LOW ? ~pat[i] : pat[i];
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            seg_q <= SEG_OFF;
            rd_q  <= '0;
        end else begin
            seg_q <= seg_d;
            if (s1_read) rd_q <= rd_d;
        end
    end

    assign seg_out     = seg_q;
    assign s1_readdata = rd_q;

endmodule

// File: tb/tb_sev_seg_ctrl.sv
// Bench for sev_seg_ctrl: directed literal checks plus randomized bus
// traffic compared every cycle against a register-level model.
`timescale 1ns/1ps
module tb_sev_seg_ctrl;

    localparam int          ND   = 4;
    localparam bit          AL   = 1'b1;
    localparam int unsigned DRST = 12_500_000;
    localparam int          NLO  = (ND > 4) ? 4 : ND;
`ifdef SEV_SEG_BLINK_EN
    localparam bit BEN = 1'b1;
`else
    localparam bit BEN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      addr = '0;
    logic            wr = 1'b0;
    logic            rd = 1'b0;
    logic [31:0]     wdata = '0;
    logic [31:0]     rdata;
    logic [7*ND-1:0] seg;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sev_seg_ctrl #(
        .NUM_DIGITS    (ND),
        .ACTIVE_LOW    (AL),
        .BLINK_DIV_RST (DRST)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .s1_address    (addr),
        .s1_write      (wr),
        .s1_writedata  (wdata),
        .s1_read       (rd),
        .s1_readdata   (rdata),
        .seg_out       (seg)
    );

    logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: register images as read back, plus cycles since last timer load
    logic [31:0]     m_reg [5];
    longint          m_ticks;
    logic [31:0]     e_rd;
    logic [7*ND-1:0] e_seg;
    bit              m_valid = 1'b0;

    function automatic logic [31:0] wmask(input int a);
        logic [63:0] t;
        logic [31:0] dm;
        dm = (32'd1 << ND) - 32'd1;
        t  = '0;
        case (a)
            0: t = (64'd1 << (4*ND)) - 64'd1;
            1: t = {32'd0, 32'd3 | (dm << 8) | (BEN ? (dm << 16) : 32'd0)};
            2: t = (64'd1 << (7*NLO)) - 64'd1;
            3: t = (ND > 4) ? (64'd1 << (7*(ND-4))) - 64'd1 : 64'd0;
            4: t = BEN ? 64'hFFFF_FFFF : 64'd0;
            default: t = '0;
        endcase
        return t[31:0];
    endfunction

    function automatic bit m_phase();
        longint per;
        if (!BEN || m_reg[4] == 32'd0) return 1'b0;
        per = longint'(m_reg[4]) + 1;
        return ((m_ticks / per) % 2) == 1;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        if (a < 3'd5) return m_reg[a];
        if (a == 3'd5) return {31'd0, m_phase()};
        return 32'd0;
    endfunction

    function automatic logic [7*ND-1:0] m_seg();
        logic [7*ND-1:0] s;
        logic [6:0]      p;
        logic [31:0]     c, rw, hx;
        logic [3:0]      nib;
        s  = '0;
        c  = m_reg[1];
        hx = m_reg[0];
        for (int i = 0; i < ND; i++) begin
            rw  = (i < 4) ? (m_reg[2] >> (7*i)) : (m_reg[3] >> (7*(i-4)));
            nib = hx[4*i +: 4];
            if (!c[0] || c[8+i])           p = 7'h00;
            else if (c[16+i] && m_phase()) p = 7'h00;
            else if (!c[1])                p = HEX[nib];
            else                           p = rw[6:0];
            s[7*i +: 7] = AL ? ~p : p;
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 5; k++) m_reg[k] = 32'd0;
            m_reg[4] = BEN ? DRST : 32'd0;
            m_ticks  = 0;
            e_seg    = {(7*ND){AL}};
            e_rd     = 32'd0;
            m_valid  = 1'b1;
        end else begin
            e_seg = m_seg();
            if (rd) e_rd = m_read(addr);
            if (wr && addr < 3'd5) m_reg[addr] = wdata & wmask(int'(addr));
            if (wr && addr == 3'd4 && BEN) m_ticks = 0;
            else m_ticks++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_seg_out", seg, e_seg);
            chk("model_readdata", rdata, e_rd);
        end
    end

    task automatic op(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
        wr = w; rd = r; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [11:0] on_pat;
    logic [2:0]  ra;
    logic [31:0] rdv;

    initial begin
        on_pat = 12'b1111_0000_1111;
        rst_n = 1'b0;
        idle(3);
        chk("rst_seg", seg, 28'hFFFFFFF);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        op(1'b0, 1'b1, 3'd4, 32'd0);
        chk("rst_blink_div", rdata, BEN ? DRST : 0);

        op(1'b1, 1'b0, 3'd0, 32'h1234);
        op(1'b1, 1'b0, 3'd1, 32'h1);
        idle(1);
        chk("hex_1234_seg", seg, {7'h79, 7'h24, 7'h30, 7'h19});
        op(1'b0, 1'b1, 3'd0, 32'd0);
        chk("hexval_read", rdata, 32'h1234);

        op(1'b1, 1'b0, 3'd1, 32'h0203);
        op(1'b1, 1'b0, 3'd2, 32'h7F);
        idle(1);
        chk("raw_blank_seg", seg, {7'h7F, 7'h7F, 7'h7F, 7'h00});

        if (BEN) begin
            op(1'b1, 1'b0, 3'd1, 32'h0001_0001);
            op(1'b1, 1'b0, 3'd4, 32'd3);
            for (int j = 0; j < 12; j++) begin
                idle(1);
                chk("blink_digit0", seg[6:0], on_pat[j] ? 7'h19 : 7'h7F);
            end
            op(1'b0, 1'b1, 3'd5, 32'd0);
            chk("status_phase1", rdata, 32'd1);
            op(1'b1, 1'b0, 3'd4, 32'd3);
            idle(1);
            chk("div_rewrite_on", seg[6:0], 7'h19);
            op(1'b0, 1'b1, 3'd5, 32'd0);
            chk("status_phase0", rdata, 32'd0);
        end else begin
            op(1'b1, 1'b0, 3'd4, 32'd3);
            op(1'b0, 1'b1, 3'd4, 32'd0);
            chk("div_ignored", rdata, 32'd0);
        end

        op(1'b1, 1'b1, 3'd0, 32'hBEEF);
        chk("rw_same_old", rdata, 32'h1234);
        op(1'b0, 1'b1, 3'd0, 32'd0);
        chk("rw_same_new", rdata, 32'hBEEF);

        op(1'b1, 1'b0, 3'd1, 32'h0001_0001);
        op(1'b1, 1'b0, 3'd4, 32'd3);
        idle(6);
        rst_n = 1'b0;
        idle(1);
        chk("midrst_seg", seg, 28'hFFFFFFF);
        chk("midrst_rdata", rdata, 0);
        rst_n = 1'b1;
        op(1'b0, 1'b1, 3'd5, 32'd0);
        chk("midrst_phase", rdata, 0);
        op(1'b0, 1'b1, 3'd4, 32'd0);
        chk("midrst_div", rdata, BEN ? DRST : 0);
        op(1'b1, 1'b0, 3'd1, 32'h00FF_0001);
        op(1'b0, 1'b1, 3'd1, 32'd0);
        chk("ctrl_mask_read", rdata, BEN ? 32'h000F_0001 : 32'h0000_0001);

        for (int c = 0; c < 4000; c++) begin
            ra  = 3'($urandom_range(0, 7));
            rdv = $urandom;
            if (ra == 3'd4) rdv = $urandom_range(0, 6);
            addr  = ra;
            wdata = rdv;
            wr    = ($urandom_range(0, 2) == 0);
            rd    = ($urandom_range(0, 1) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end
        wr = 1'b0; rd = 1'b0; rst_n = 1'b1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
